// File: rtl/generador_pwm_servos_pkg.sv
// Shared constants, types and helpers for the four-channel servo PWM generator.
package generador_pwm_servos_pkg;

  localparam int CICLOS_POR_US_DEF = 50;
  localparam int PERIODO_US_DEF    = 20000;
  localparam int PULSO_MIN_US_DEF  = 1000;
  localparam int PASO_Q8_DEF       = 1422;
  localparam int ANGULO_MAX_DEF    = 180;
  localparam int ANGULO_RESET_DEF  = 90;
  localparam int PASO_MAX_DEF      = 0;

  localparam int NUM_CANALES    = 4;
  localparam int ANCHO_ANGULO   = 8;
  localparam int ANCHO_PERIODO  = 15;
  localparam int ANCHO_PULSO    = 11;
  localparam int ANCHO_PRODUCTO = 18;

  typedef logic [ANCHO_ANGULO-1:0]   angulo_t;
  typedef logic [ANCHO_PERIODO-1:0]  cnt_periodo_t;
  typedef logic [ANCHO_PULSO-1:0]    ancho_us_t;
  typedef logic [ANCHO_PRODUCTO-1:0] producto_t;

  function automatic angulo_t limitar_angulo(input angulo_t angulo, input angulo_t maximo);
    return (angulo > maximo) ? maximo : angulo;
  endfunction

endpackage

// File: rtl/generador_pwm_servos_canal.sv
// One servo channel: clamps the target angle, slews the applied angle once per
// frame, converts it to a pulse width in microseconds and drives the PWM line.
module canal_pwm_servo
  import generador_pwm_servos_pkg::*;
#(
  parameter int PULSO_MIN_US = PULSO_MIN_US_DEF,
  parameter int PASO_Q8      = PASO_Q8_DEF,
  parameter int ANGULO_MAX   = ANGULO_MAX_DEF,
  parameter int ANGULO_RESET = ANGULO_RESET_DEF,
  parameter int PASO_MAX     = PASO_MAX_DEF
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         frontera,
  input  logic         hab_q,
  input  cnt_periodo_t cnt_periodo,
  input  angulo_t      angulo_in,
  output logic         pwm
);

  localparam angulo_t   ANG_MAX   = angulo_t'(ANGULO_MAX);
  localparam angulo_t   ANG_RESET = angulo_t'(ANGULO_RESET);
  localparam angulo_t   PASO      = angulo_t'(PASO_MAX);
  localparam producto_t PASO_Q8_V = producto_t'(PASO_Q8);
  localparam producto_t PULSO_MIN = producto_t'(PULSO_MIN_US);

  angulo_t   obj;
  angulo_t   dif;
  angulo_t   apl_q;
  angulo_t   apl_d;
  producto_t producto;
  ancho_us_t ancho_us;
  logic      pwm_q;
  logic      pwm_d;

  // Clamp the target and move the applied angle toward it, only at frame boundaries
  always_comb begin
    obj   = limitar_angulo(angulo_in, ANG_MAX);
    dif   = (obj >= apl_q) ? (obj - apl_q) : (apl_q - obj);
    apl_d = apl_q;
    if (frontera) begin
      if ((PASO_MAX == 0) || (dif <= PASO)) begin
        apl_d = obj;
      end else if (obj > apl_q) begin
        apl_d = apl_q + PASO;
      end else begin
        apl_d = apl_q - PASO;
      end
    end
  end

  // Pulse width from the applied angle (Q8.8 scale, truncated) and frame-position compare
  always_comb begin
    producto = producto_t'(apl_q) * PASO_Q8_V;
    ancho_us = ancho_us_t'(PULSO_MIN + (producto >> 8));
    pwm_d    = hab_q && (cnt_periodo < cnt_periodo_t'(ancho_us));
  end

  // Applied-angle register and registered PWM output
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      apl_q <= ANG_RESET;
      pwm_q <= 1'b0;
    end else begin
      apl_q <= apl_d;
      pwm_q <= pwm_d;
    end
  end

  assign pwm = pwm_q;

endmodule

// File: rtl/generador_pwm_servos.sv
// Four-channel hobby-servo PWM generator: shared microsecond prescaler, frame
// counter and frame-start pulse feeding four identical channel instances.
module generador_pwm_servos
  import generador_pwm_servos_pkg::*;
#(
  parameter int CICLOS_POR_US = CICLOS_POR_US_DEF,
  parameter int PERIODO_US    = PERIODO_US_DEF,
  parameter int PULSO_MIN_US  = PULSO_MIN_US_DEF,
  parameter int PASO_Q8       = PASO_Q8_DEF,
  parameter int ANGULO_MAX    = ANGULO_MAX_DEF,
  parameter int ANGULO_RESET  = ANGULO_RESET_DEF,
  parameter int PASO_MAX      = PASO_MAX_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       habilitar,
  input  logic [7:0] angulo_servo_1,
  input  logic [7:0] angulo_servo_2,
  input  logic [7:0] angulo_servo_3,
  input  logic [7:0] angulo_servo_4,
  output logic       pwm_servo_1,
  output logic       pwm_servo_2,
  output logic       pwm_servo_3,
  output logic       pwm_servo_4,
  output logic       inicio_periodo
);

  localparam int ANCHO_US = $clog2(CICLOS_POR_US + 1);
  localparam logic [ANCHO_US-1:0] US_FIN  = ANCHO_US'(CICLOS_POR_US - 1);
  localparam cnt_periodo_t        PER_FIN = cnt_periodo_t'(PERIODO_US - 1);

  logic [ANCHO_US-1:0] cnt_us_q;
  logic [ANCHO_US-1:0] cnt_us_d;
  cnt_periodo_t        cnt_periodo_q;
  cnt_periodo_t        cnt_periodo_d;
  logic                hab_q;
  logic                hab_d;
  logic                inicio_q;
  logic                inicio_d;
  logic                tick_us;
  logic                frontera;

  angulo_t                angulos [NUM_CANALES];
  logic [NUM_CANALES-1:0] pwm;

  // Prescaler, frame counter, enable latch and frame-start pulse next-state
  always_comb begin
    tick_us       = (cnt_us_q == US_FIN);
    frontera      = tick_us && (cnt_periodo_q == PER_FIN);
    cnt_us_d      = tick_us ? '0 : (cnt_us_q + ANCHO_US'(1));
    cnt_periodo_d = cnt_periodo_q;
    if (frontera) begin
      cnt_periodo_d = '0;
    end else if (tick_us) begin
      cnt_periodo_d = cnt_periodo_q + cnt_periodo_t'(1);
    end
    hab_d    = frontera ? habilitar : hab_q;
    inicio_d = frontera;
  end

  // Shared timing registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_us_q      <= '0;
      cnt_periodo_q <= '0;
      hab_q         <= 1'b0;
      inicio_q      <= 1'b0;
    end else begin
      cnt_us_q      <= cnt_us_d;
      cnt_periodo_q <= cnt_periodo_d;
      hab_q         <= hab_d;
      inicio_q      <= inicio_d;
    end
  end

  assign angulos[0] = angulo_servo_1;
  assign angulos[1] = angulo_servo_2;
  assign angulos[2] = angulo_servo_3;
  assign angulos[3] = angulo_servo_4;

  for (genvar g = 0; g < NUM_CANALES; g++) begin : g_canal
    canal_pwm_servo #(
      .PULSO_MIN_US (PULSO_MIN_US),
      .PASO_Q8      (PASO_Q8),
      .ANGULO_MAX   (ANGULO_MAX),
      .ANGULO_RESET (ANGULO_RESET),
      .PASO_MAX     (PASO_MAX)
    ) u_canal (
      .clk         (clk),
      .reset_n     (reset_n),
      .frontera    (frontera),
      .hab_q       (hab_q),
      .cnt_periodo (cnt_periodo_q),
      .angulo_in   (angulos[g]),
      .pwm         (pwm[g])
    );
  end

  assign pwm_servo_1    = pwm[0];
  assign pwm_servo_2    = pwm[1];
  assign pwm_servo_3    = pwm[2];
  assign pwm_servo_4    = pwm[3];
  assign inicio_periodo = inicio_q;

endmodule

// File: tb/tb_generador_pwm_servos.sv
// Bench for generador_pwm_servos: two instances (no slew limit, and a 4-degree
// slew limit) share every input; each frame the high time of every line is
// measured and compared with a per-frame angle/width model.
module tb_generador_pwm_servos;

  localparam int CICLOS  = 1;
  localparam int PERIODO = 2000;
  localparam int PASO    = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       habilitar;
  logic [7:0] ang [4];
  logic [3:0] pwmA;
  logic [3:0] pwmB;
  logic       inicioA;
  logic       inicioB;

  int vectors = 0;
  int miscompares = 0;

  int   aplA [4];
  int   aplB [4];
  bit   habM;
  int   measA [4];
  int   measB [4];
  logic [7:0] pendAng [4];
  logic pendHab;
  int   slewTab [4];

  // Free-running clock for both instances
  always #5 clk = ~clk;

  generador_pwm_servos #(
    .CICLOS_POR_US(CICLOS), .PERIODO_US(PERIODO), .PASO_MAX(0)
  ) dutA (
    .clk(clk), .reset_n(reset_n), .habilitar(habilitar),
    .angulo_servo_1(ang[0]), .angulo_servo_2(ang[1]),
    .angulo_servo_3(ang[2]), .angulo_servo_4(ang[3]),
    .pwm_servo_1(pwmA[0]), .pwm_servo_2(pwmA[1]),
    .pwm_servo_3(pwmA[2]), .pwm_servo_4(pwmA[3]),
    .inicio_periodo(inicioA)
  );

  generador_pwm_servos #(
    .CICLOS_POR_US(CICLOS), .PERIODO_US(PERIODO), .PASO_MAX(PASO)
  ) dutB (
    .clk(clk), .reset_n(reset_n), .habilitar(habilitar),
    .angulo_servo_1(ang[0]), .angulo_servo_2(ang[1]),
    .angulo_servo_3(ang[2]), .angulo_servo_4(ang[3]),
    .pwm_servo_1(pwmB[0]), .pwm_servo_2(pwmB[1]),
    .pwm_servo_3(pwmB[2]), .pwm_servo_4(pwmB[3]),
    .inicio_periodo(inicioB)
  );

  function automatic int anchoEsperado(input int grados);
    return 1000 + (grados * 1422) / 256;
  endfunction

  task automatic checkOutput(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] a0, input logic [7:0] a1,
                               input logic [7:0] a2, input logic [7:0] a3,
                               input logic h);
    ang[0] = a0;
    ang[1] = a1;
    ang[2] = a2;
    ang[3] = a3;
    habilitar = h;
  endtask

  task automatic modelReset();
    for (int i = 0; i < 4; i++) begin
      aplA[i] = 90;
      aplB[i] = 90;
    end
    habM = 1'b0;
  endtask

  task automatic modelBoundary();
    int obj;
    habM = habilitar;
    for (int i = 0; i < 4; i++) begin
      obj = (int'(ang[i]) > 180) ? 180 : int'(ang[i]);
      aplA[i] = obj;
      if (obj > aplB[i] + PASO)      aplB[i] = aplB[i] + PASO;
      else if (obj < aplB[i] - PASO) aplB[i] = aplB[i] - PASO;
      else                           aplB[i] = obj;
    end
  endtask

  task automatic quietFrame();
    int altos;
    int inicios;
    altos = 0;
    inicios = 0;
    for (int k = 0; k < PERIODO * CICLOS; k++) begin
      if (k > 0) @(negedge clk);
      altos   += $countones(pwmA) + $countones(pwmB);
      inicios += int'(inicioA) + int'(inicioB);
    end
    checkOutput("post-reset frame pwm high cycles", altos, 0);
    checkOutput("post-reset frame inicio pulses", inicios, 0);
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset pwm", int'({pwmA, pwmB}), 0);
    checkOutput("reset inicio", int'({inicioA, inicioB}), 0);
    modelReset();
    reset_n = 1'b1;
    quietFrame();
  endtask

  task automatic waitFrameStart();
    int espera;
    espera = 0;
    do begin
      @(negedge clk);
      espera++;
    end while (!(inicioA === 1'b1 && inicioB === 1'b1) && espera < PERIODO * CICLOS + 100);
    checkOutput("frame start latency", espera, 1);
  endtask

  task automatic runFrame(input int cambioEn);
    int inicios;
    modelBoundary();
    waitFrameStart();
    inicios = 0;
    for (int i = 0; i < 4; i++) begin
      measA[i] = 0;
      measB[i] = 0;
    end
    for (int k = 0; k < PERIODO * CICLOS; k++) begin
      if (k > 0) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        measA[i] += int'(pwmA[i]);
        measB[i] += int'(pwmB[i]);
      end
      inicios += int'(inicioA) + int'(inicioB);
      if (k == cambioEn) begin
        for (int i = 0; i < 4; i++) ang[i] = pendAng[i];
        habilitar = pendHab;
      end
    end
    checkOutput("inicio pulses per frame", inicios, 2);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("width A ch%0d", i + 1), measA[i],
                  habM ? anchoEsperado(aplA[i]) * CICLOS : 0);
      checkOutput($sformatf("width B ch%0d", i + 1), measB[i],
                  habM ? anchoEsperado(aplB[i]) * CICLOS : 0);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    slewTab[0] = 1522;
    slewTab[1] = 1544;
    slewTab[2] = 1555;
    slewTab[3] = 1555;
    applyStimulus(8'd100, 8'd100, 8'd100, 8'd100, 1'b1);
    for (int i = 0; i < 4; i++) pendAng[i] = 8'd100;
    pendHab = 1'b1;
    @(negedge clk);

    $display("[TB] reset, then slew from 90 toward 100");
    doReset();
    for (int f = 0; f < 4; f++) begin
      runFrame(-1);
      checkOutput($sformatf("slew frame %0d", f + 1), measB[0], slewTab[f]);
    end
    checkOutput("unlimited at 100 deg", measA[0], 1555);

    $display("[TB] angle boundaries 90/180/255/0");
    applyStimulus(8'd90, 8'd180, 8'd255, 8'd0, 1'b1);
    runFrame(-1);
    checkOutput("angle 90", measA[0], 1499);
    checkOutput("angle 180", measA[1], 1999);
    checkOutput("angle 255 clamped", measA[2], 1999);
    checkOutput("angle 0", measA[3], 1000);

    $display("[TB] mid-frame angle change");
    applyStimulus(8'd0, 8'd0, 8'd0, 8'd0, 1'b1);
    runFrame(-1);
    checkOutput("angle 0 all", measA[0], 1000);
    for (int i = 0; i < 4; i++) pendAng[i] = 8'd180;
    pendHab = 1'b1;
    runFrame(500);
    checkOutput("current pulse unaffected", measA[0], 1000);
    runFrame(-1);
    checkOutput("next frame new angle", measA[0], 1999);

    $display("[TB] habilitar dropped mid-pulse");
    for (int i = 0; i < 4; i++) pendAng[i] = ang[i];
    pendHab = 1'b0;
    runFrame(300);
    checkOutput("pulse completes", measA[0], 1999);
    runFrame(-1);
    checkOutput("disabled frame low", measA[0], 0);

    $display("[TB] random frames");
    for (int r = 0; r < 6; r++) begin
      applyStimulus(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    1'($urandom_range(0, 3) != 0));
      for (int i = 0; i < 4; i++) pendAng[i] = 8'($urandom_range(0, 255));
      pendHab = 1'($urandom_range(0, 3) != 0);
      runFrame(($urandom_range(0, 1) == 1) ? int'($urandom_range(0, PERIODO - 1)) : -1);
    end

    $display("[TB] reset mid-pulse");
    applyStimulus(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b1);
    modelBoundary();
    waitFrameStart();
    repeat (500) @(negedge clk);
    checkOutput("pulse running before reset", int'(pwmA[0]), 1);
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("pwm low after reset", int'({pwmA, pwmB}), 0);
    checkOutput("inicio low after reset", int'({inicioA, inicioB}), 0);
    applyStimulus(8'd45, 8'd135, 8'd200, 8'd3, 1'b1);
    doReset();
    runFrame(-1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
